// File: rtl/uart_tx_if.sv
// Word handshake between the debug command/log source (master) and the UART transmitter (slave).
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] txd;
  logic                  txv;
  logic                  rdy;

  modport master (output txd, output txv, input rdy);
  modport slave  (input txd, input txv, output rdy);
endinterface

// File: rtl/uart_tx.sv
// Debug UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional one-word holding register for back-to-back frames: define UART_TX_HOLD_EN.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 1,
  parameter int EVEN       = 1,
  parameter int PRESCALER  = 15
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave host,
  output logic     tx,
  output logic     busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam int PSK_W = $clog2(PRESCALER);
  localparam int BIT_W = $clog2(DATA_WIDTH + STOP_BITS + 2);
  localparam logic [PSK_W-1:0] PSK_LAST  = PSK_W'(PRESCALER - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  state_t                state_reg, state_next;
  logic [PSK_W-1:0]      psk_ctr;
  logic [BIT_W-1:0]      bit_ctr;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_reg;
  logic                  tx_reg, tx_next;
  logic                  wrap, frame_end;
  logic                  accept, load, rdy_int;
  logic [DATA_WIDTH-1:0] load_data;

  assign wrap      = (psk_ctr == PSK_LAST);
  assign frame_end = (state_reg == STOP) && wrap && (bit_ctr == STOP_LAST);

`ifdef UART_TX_HOLD_EN
  logic                  hold_full_reg;
  logic [DATA_WIDTH-1:0] hold_data_reg;

  // A word arriving while idle, or exactly as the frame ends, goes straight to the shifter.
  assign accept    = host.txv && !hold_full_reg;
  assign load      = (accept && (state_reg == IDLE || frame_end)) || (frame_end && hold_full_reg);
  assign load_data = hold_full_reg ? hold_data_reg : host.txd;
  assign rdy_int   = !hold_full_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
    end else if (frame_end && hold_full_reg) begin
      hold_full_reg <= 1'b0;
    end else if (accept && !load) begin
      hold_full_reg <= 1'b1;
      hold_data_reg <= host.txd;
    end
  end
`else
  assign accept    = host.txv && (state_reg == IDLE);
  assign load      = accept;
  assign load_data = host.txd;
  assign rdy_int   = (state_reg == IDLE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      psk_ctr   <= '0;
      bit_ctr   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      tx_reg    <= tx_next;
      if (state_reg == IDLE || wrap)
        psk_ctr <= '0;
      else
        psk_ctr <= psk_ctr + 1'b1;
      // bit_ctr counts bits within the current state only
      if (state_next != state_reg)
        bit_ctr <= '0;
      else if (wrap)
        bit_ctr <= bit_ctr + 1'b1;
      if (load) begin
        shift_reg <= load_data;
        par_reg   <= (EVEN != 0) ? ^load_data : ~^load_data;
      end else if (state_reg == DATA && wrap) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = START;
      START:   if (wrap) state_next = DATA;
      DATA:    if (wrap && bit_ctr == DATA_LAST) state_next = (PARITY != 0) ? PAR : STOP;
      PAR:     if (wrap) state_next = STOP;
      STOP:    if (frame_end) state_next = load ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line trails the FSM by one clock.
  always_comb begin
    tx_next  = 1'b1;
    busy     = (state_reg != IDLE);
    host.rdy = rdy_int;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      PAR:     tx_next = par_reg;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx = tx_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor decodes frames and compares them with a scoreboard.
module tb_uart_tx;
`ifdef UART_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] txd_drv = '0;
  logic       txv_drv = 1'b0;
  int         sel = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         hs_cyc = 0;
  frame_t     sb[$];
  int         starts[$];

  logic tx0, tx1, tx2, busy0, busy1, busy2;
  logic sel_tx, sel_rdy, sel_busy;

  uart_tx_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_if #(.DATA_WIDTH(8)) bus1 ();
  uart_tx_if #(.DATA_WIDTH(8)) bus2 ();

  assign bus0.txd = txd_drv;
  assign bus1.txd = txd_drv;
  assign bus2.txd = txd_drv;
  assign bus0.txv = txv_drv && (sel == 0);
  assign bus1.txv = txv_drv && (sel == 1);
  assign bus2.txv = txv_drv && (sel == 2);

  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY(1), .EVEN(1), .PRESCALER(15)) u_main (
    .clk(clk), .rst(rst), .host(bus0), .tx(tx0), .busy(busy0));
  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY(1), .EVEN(0), .PRESCALER(15)) u_odd (
    .clk(clk), .rst(rst), .host(bus1), .tx(tx1), .busy(busy1));
  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(2), .PARITY(0), .EVEN(1), .PRESCALER(15)) u_nopar (
    .clk(clk), .rst(rst), .host(bus2), .tx(tx2), .busy(busy2));

  always_comb begin
    case (sel)
      1:       begin sel_tx = tx1; sel_rdy = bus1.rdy; sel_busy = busy1; end
      2:       begin sel_tx = tx2; sel_rdy = bus2.rdy; sel_busy = busy2; end
      default: begin sel_tx = tx0; sel_rdy = bus0.rdy; sel_busy = busy0; end
    endcase
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame for the main instance: start, data LSB first, even parity, one stop.
  function automatic frame_t model(input logic [7:0] d);
    frame_t f;
    f.bits = {5'b0, 1'b1, ^d, d, 1'b0};
    f.n    = 11;
    return f;
  endfunction

  // Line monitor: samples each bit at its centre, abandons a frame when mon_en drops.
  logic [15:0] mon_bits;
  int          mon_n;
  bit          mon_abort;
  frame_t      mon_exp;
  always begin : monitor
    @(negedge clk);
    if (mon_en && sel_tx === 1'b0) begin
      starts.push_back(cyc);
      mon_n     = (sb.size() > 0) ? sb[0].n : 11;
      mon_bits  = '0;
      mon_abort = 1'b0;
      for (int i = 0; i < mon_n && !mon_abort; i++) begin
        for (int k = 0; k < ((i == 0) ? 7 : 15); k++) begin
          @(negedge clk);
          if (!mon_en) begin
            mon_abort = 1'b1;
            break;
          end
        end
        mon_bits[i] = sel_tx;
      end
      if (!mon_abort) begin
        check("frame_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check("frame_bits", 32'(mon_bits), 32'(mon_exp.bits));
          $display("frame sel=%0d bits=%03h expected=%03h", sel, mon_bits, mon_exp.bits);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input frame_t e);
    int w;
    @(negedge clk);
    txd_drv = d;
    txv_drv = 1'b1;
    w = 0;
    while (!sel_rdy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("rdy_wait", 32'(sel_rdy), 32'd1);
    hs_cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 txv_drv = 1'b0;
  endtask

  task automatic measure_busy(input int start, output int cnt);
    cnt = start;
    forever begin
      @(negedge clk);
      if (!sel_busy || cnt >= 400) break;
      cnt++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while ((sel_busy || sb.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check(tag, 32'(w < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    int cnt, w, ns, h1;
    frame_t f;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_rdy", 32'(bus0.rdy), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    check("rel_rdy", 32'(bus0.rdy), 32'd1);

    // 8'hA5: latency, frame bits, busy/rdy duration
    f = '{16'h054A, 11};
    send(8'hA5, f);
    @(negedge clk);
    check("lat_pre_tx", 32'(tx0), 32'd1);
    check("busy_rise", 32'(busy0), 32'd1);
    check("rdy_in_frame", 32'(bus0.rdy), 32'(HOLD));
    @(negedge clk);
    check("lat_start_tx", 32'(tx0), 32'd0);
    measure_busy(2, cnt);
    check("busy_len_a5", 32'(cnt), 32'd165);
    wait_idle("idle_a5");

    // Odd parity, 8'h00 -> parity 1
    sel = 1;
    f = '{16'h0600, 11};
    send(8'h00, f);
    wait_idle("idle_odd");

    // No parity, two stop bits, 8'hFF
    sel = 2;
    f = '{16'h07FE, 11};
    send(8'hFF, f);
    measure_busy(0, cnt);
    check("busy_len_nopar", 32'(cnt), 32'd165);
    wait_idle("idle_nopar");
    sel = 0;
    repeat (3) @(negedge clk);

`ifndef UART_TX_HOLD_EN
    // txv held high with changing txd: only the first word is sent, next frame after 1 idle clk
    send(8'h5A, model(8'h5A));
    txv_drv = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (sel_rdy || w > 400) break;
      txd_drv = w[0] ? 8'hC3 : 8'h3C;
      w++;
    end
    check("held_txv_timeout", 32'(w <= 400), 32'd1);
    txd_drv = 8'h96;
    sb.push_back(model(8'h96));
    @(posedge clk);
    #1 txv_drv = 1'b0;
    wait_idle("idle_held");
    check("held_gap", 32'(starts[starts.size()-1] - starts[starts.size()-2]), 32'd166);
`endif

    // Reset during DATA bit 4 (tx low there for 8'hE1), then a clean 8'h3C
    send(8'hE1, model(8'hE1));
    repeat (80) @(negedge clk);
    mon_en = 1'b0;
    check("pre_rst_tx", 32'(tx0), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx0), 32'd1);
    check("rst_mid_busy", 32'(busy0), 32'd0);
    check("rst_mid_rdy", 32'(bus0.rdy), 32'd1);
    repeat (3) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(bus0.rdy), 32'd1);
    check("post_rst_busy", 32'(busy0), 32'd0);
    mon_en = 1'b1;
    send(8'h3C, model(8'h3C));
    wait_idle("idle_3c");

`ifdef UART_TX_HOLD_EN
    // Three back-to-back writes: 2nd into holding register, 3rd stalls until frame 2 starts
    ns = starts.size();
    send(8'h11, model(8'h11));
    h1 = hs_cyc;
    send(8'h22, model(8'h22));
    @(negedge clk);
    check("hold_full_rdy", 32'(bus0.rdy), 32'd0);
    send(8'h33, model(8'h33));
    check("hold_release", 32'(hs_cyc - h1), 32'd166);
    wait_idle("idle_hold");
    check("hold_gap12", 32'(starts[ns+1] - starts[ns]), 32'd165);
    check("hold_gap23", 32'(starts[ns+2] - starts[ns+1]), 32'd165);
`endif

    // Every data value through the main instance
    for (int v = 0; v < 256; v++) send(8'(v), model(8'(v)));
    wait_idle("idle_sweep");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
